// File: rtl/accum_sched.sv
// accum_sched: time-multiplexed bank of leaky event accumulators with a
// trigger FIFO.
//
// Each channel keeps a saturating count and a leak timer. An accepted inc
// event raises the count; a decay event lowers it (floor 0). Every
// PUSH_DOWN-th event on a channel applies one extra leak decrement. When an
// inc event lands on a count of THRESHOLD-1 the channel fires: the count
// returns to 0 and the channel number is pushed into the trigger FIFO.
// A clr_in pulse starts a sweep that zeroes one channel per cycle. Events
// are held off during the sweep, but queued triggers stay poppable.
//
// Optional feature: define ACCUM_SCHED_STATS_EN to add trig_total_out, a
// saturating 16-bit count of FIFO pushes. It is cleared by rst_in only.
//
// Ports:
//   clk_in          rising-edge clock
//   rst_in          synchronous active-high reset
//   ev_valid_in     event offered
//   ev_ready_out    event accepted this cycle if valid (combinational)
//   ev_ch_in        target channel of the event
//   ev_inc_in       1 = increment event, 0 = decay event
//   clr_in          pulse that starts (or restarts) a clear sweep
//   trig_valid_out  trigger FIFO head valid
//   trig_ready_in   consumer pops the head
//   trig_ch_out     channel held at the FIFO head
//   busy_out        high while the sweep is running
//   trig_total_out  (ACCUM_SCHED_STATS_EN only) saturating push count

module accum_sched #(
  parameter int N_CH       = 8,
  parameter int THRESHOLD  = 255,
  parameter int PUSH_DOWN  = 16,
  parameter int TRIG_DEPTH = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    ev_valid_in,
  output logic                    ev_ready_out,
  input  logic [$clog2(N_CH)-1:0] ev_ch_in,
  input  logic                    ev_inc_in,
  input  logic                    clr_in,
  output logic                    trig_valid_out,
  input  logic                    trig_ready_in,
  output logic [$clog2(N_CH)-1:0] trig_ch_out,
  output logic                    busy_out
`ifdef ACCUM_SCHED_STATS_EN
  ,
  output logic [15:0]             trig_total_out
`endif
);

  localparam int CH_W    = $clog2(N_CH);
  localparam int COUNT_W = $clog2(THRESHOLD);
  localparam int TMR_W   = $clog2(PUSH_DOWN);
  localparam int PTR_W   = $clog2(TRIG_DEPTH);
  localparam int OCC_W   = $clog2(TRIG_DEPTH + 1);

  typedef enum logic {
    S_RUN,
    S_SWEEP
  } state_t;

  // Per-channel state
  logic [COUNT_W-1:0] r_count [N_CH];
  logic [TMR_W-1:0]   r_timer [N_CH];

  // Sweep FSM
  state_t             r_state;
  state_t             w_state_nxt;
  logic [CH_W-1:0]    r_sweep_idx;
  logic [CH_W-1:0]    w_sweep_idx_nxt;
  logic               w_sweep_clr;

  // Trigger FIFO
  logic [CH_W-1:0]    r_fifo [TRIG_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]   r_occ;

  // Event datapath
  logic               w_accept;
  logic               w_fire;
  logic               w_push;
  logic               w_pop;
  logic [COUNT_W-1:0] w_cur_count;
  logic [COUNT_W-1:0] w_base_count;
  logic [COUNT_W-1:0] w_new_count;
  logic [TMR_W-1:0]   w_cur_timer;
  logic [TMR_W-1:0]   w_new_timer;

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
  assign ev_ready_out   = (r_state == S_RUN) && !clr_in &&
                          (r_occ < OCC_W'(TRIG_DEPTH));
  assign w_accept       = ev_valid_in && ev_ready_out;
  assign w_push         = w_accept && w_fire;
  assign trig_valid_out = (r_occ != '0);
  assign w_pop          = trig_valid_out && trig_ready_in;
  assign trig_ch_out    = r_fifo[r_rd_ptr];
  assign busy_out       = (r_state == S_SWEEP);

  // ---------------------------------------------------------------------
  // Event update for the addressed channel
  // ---------------------------------------------------------------------
  always_comb begin
    w_cur_count  = r_count[ev_ch_in];
    w_cur_timer  = r_timer[ev_ch_in];
    w_new_timer  = (w_cur_timer == TMR_W'(PUSH_DOWN - 1)) ? '0
                                                          : w_cur_timer + 1'b1;
    w_fire       = ev_inc_in && (w_cur_count == COUNT_W'(THRESHOLD - 1));

    if (w_fire) begin
      w_base_count = '0;
    end else if (ev_inc_in) begin
      w_base_count = w_cur_count + 1'b1;
    end else if (w_cur_count != '0) begin
      w_base_count = w_cur_count - 1'b1;
    end else begin
      w_base_count = '0;
    end

    // Leak tick: one more saturating decrement when the timer wraps.
    w_new_count = w_base_count;
    if ((w_new_timer == '0) && (w_base_count != '0)) begin
      w_new_count = w_base_count - 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_RUN;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    w_sweep_clr     = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (clr_in) begin
          w_state_nxt     = S_SWEEP;
          w_sweep_idx_nxt = '0;
        end
      end
      S_SWEEP: begin
        if (clr_in) begin
          // A fresh clear restarts the walk from channel 0.
          w_sweep_idx_nxt = '0;
        end else begin
          w_sweep_clr = 1'b1;
          if (r_sweep_idx == CH_W'(N_CH - 1)) begin
            w_state_nxt     = S_RUN;
            w_sweep_idx_nxt = '0;
          end else begin
            w_sweep_idx_nxt = r_sweep_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt     = S_RUN;
        w_sweep_idx_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Channel registers (sweep and event acceptance never coincide)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rst_in) begin
        r_count[i] <= '0;
        r_timer[i] <= '0;
      end else if (w_sweep_clr && (r_sweep_idx == CH_W'(i))) begin
        r_count[i] <= '0;
        r_timer[i] <= '0;
      end else if (w_accept && (ev_ch_in == CH_W'(i))) begin
        r_count[i] <= w_new_count;
        r_timer[i] <= w_new_timer;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Trigger FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= ev_ch_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(TRIG_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(TRIG_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - 1'b1;
      end
    end
  end

`ifdef ACCUM_SCHED_STATS_EN
  // ---------------------------------------------------------------------
  // Push statistics
  // ---------------------------------------------------------------------
  logic [15:0] r_total;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_total <= '0;
    end else if (w_push && (r_total != '1)) begin
      r_total <= r_total + 16'd1;
    end
  end

  assign trig_total_out = r_total;
`endif

endmodule

// File: tb/tb_accum_sched.sv
// Self-checking bench for accum_sched. Two instances with different
// parameters share one stimulus stream; a behavioural model per instance
// predicts every output each cycle, and directed scenarios add literal
// expectations.
module tb_accum_sched;

  localparam int NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ev_valid;
  logic [1:0] ev_ch;
  logic       ev_inc;
  logic       clr;
  logic       tready;

  logic [1:0] w_ready;
  logic [1:0] w_tvalid;
  logic [1:0] w_busy;
  logic [1:0] w_tch [2];
`ifdef ACCUM_SCHED_STATS_EN
  logic [15:0] w_total [2];
`endif

  accum_sched #(.N_CH(4), .THRESHOLD(4), .PUSH_DOWN(16), .TRIG_DEPTH(2)) u_a (
    .clk_in(clk), .rst_in(rst), .ev_valid_in(ev_valid), .ev_ready_out(w_ready[0]),
    .ev_ch_in(ev_ch), .ev_inc_in(ev_inc), .clr_in(clr),
    .trig_valid_out(w_tvalid[0]), .trig_ready_in(tready),
    .trig_ch_out(w_tch[0]), .busy_out(w_busy[0])
`ifdef ACCUM_SCHED_STATS_EN
    , .trig_total_out(w_total[0])
`endif
  );

  accum_sched #(.N_CH(4), .THRESHOLD(8), .PUSH_DOWN(4), .TRIG_DEPTH(4)) u_b (
    .clk_in(clk), .rst_in(rst), .ev_valid_in(ev_valid), .ev_ready_out(w_ready[1]),
    .ev_ch_in(ev_ch), .ev_inc_in(ev_inc), .clr_in(clr),
    .trig_valid_out(w_tvalid[1]), .trig_ready_in(tready),
    .trig_ch_out(w_tch[1]), .busy_out(w_busy[1])
`ifdef ACCUM_SCHED_STATS_EN
    , .trig_total_out(w_total[1])
`endif
  );

  // ---------------------------------------------------------------------
  // Behavioural model (one per instance)
  // ---------------------------------------------------------------------
  int p_th [2] = '{4, 8};
  int p_pd [2] = '{16, 4};
  int p_td [2] = '{2, 4};

  int m_cnt   [2][NCH];
  int m_tmr   [2][NCH];
  int m_fifo  [2][8];
  int m_head  [2];
  int m_occ   [2];
  int m_sweep [2];   // channels still to be cleared; 0 means running
  int m_total [2];
  bit m_live = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int k);
    return (m_sweep[k] == 0) && !clr && (m_occ[k] < p_td[k]);
  endfunction

  task automatic m_step(input int k);
    bit acc, pop, fire;
    int c, t, nt, b, ch;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[k][i] = 0;
        m_tmr[k][i] = 0;
      end
      m_head[k] = 0; m_occ[k] = 0; m_sweep[k] = 0; m_total[k] = 0;
      return;
    end
    acc = ev_valid && m_ready(k);
    pop = (m_occ[k] > 0) && tready;
    if (clr) begin
      m_sweep[k] = NCH;
    end else if (m_sweep[k] > 0) begin
      ch = NCH - m_sweep[k];
      m_cnt[k][ch] = 0;
      m_tmr[k][ch] = 0;
      m_sweep[k]--;
    end
    if (pop) begin
      m_head[k] = (m_head[k] + 1) % p_td[k];
      m_occ[k]--;
    end
    if (acc) begin
      ch   = int'(ev_ch);
      c    = m_cnt[k][ch];
      t    = m_tmr[k][ch];
      nt   = (t + 1) % p_pd[k];
      fire = ev_inc && (c == p_th[k] - 1);
      if (fire)        b = 0;
      else if (ev_inc) b = c + 1;
      else             b = (c > 0) ? c - 1 : 0;
      if (nt == 0 && b > 0) b--;
      m_cnt[k][ch] = b;
      m_tmr[k][ch] = nt;
      if (fire) begin
        m_fifo[k][(m_head[k] + m_occ[k]) % p_td[k]] = ch;
        m_occ[k]++;
        if (m_total[k] < 65535) m_total[k]++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    m_step(0);
    m_step(1);
    if (rst) m_live = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        string id;
        id = (k == 0) ? "A" : "B";
        chk({id, ".ready"},  int'(w_ready[k]),  int'(m_ready(k)));
        chk({id, ".tvalid"}, int'(w_tvalid[k]), int'(m_occ[k] > 0));
        chk({id, ".busy"},   int'(w_busy[k]),   int'(m_sweep[k] > 0));
        if (m_occ[k] > 0) chk({id, ".tch"}, int'(w_tch[k]), m_fifo[k][m_head[k]]);
`ifdef ACCUM_SCHED_STATS_EN
        chk({id, ".total"}, int'(w_total[k]), m_total[k]);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic cyc(input bit v, input int ch, input bit inc, input bit c);
    ev_valid = v; ev_ch = 2'(ch); ev_inc = inc; clr = c;
    @(posedge clk); #1;
    ev_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ev_valid = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b1; ev_valid = 1'b0; ev_ch = '0; ev_inc = 1'b0; clr = 1'b0; tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    for (int k = 0; k < 2; k++) begin
      chk("rst.tvalid", int'(w_tvalid[k]), 0);
      chk("rst.busy",   int'(w_busy[k]),   0);
      chk("rst.ready",  int'(w_ready[k]),  1);
    end

    // Four back-to-back incs on ch2 fire one cycle after the 4th acceptance
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 2, 1, 0);
      if (i < 3) chk("b2b.noearly", int'(w_tvalid[0]), 0);
    end
    chk("b2b.tvalid", int'(w_tvalid[0]), 1);
    chk("b2b.tch",    int'(w_tch[0]),    2);
    cyc(0, 0, 0, 0);
    chk("b2b.popped", int'(w_tvalid[0]), 0);

    // Decay floors at 0: inc,inc,dec x3, inc x3 -> no fire; next inc fires
    cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
    repeat (3) cyc(1, 1, 0, 0);
    repeat (3) cyc(1, 1, 1, 0);
    chk("floor.nofire", int'(w_tvalid[0]), 0);
    cyc(1, 1, 1, 0);
    chk("floor.fire",   int'(w_tvalid[0]), 1);
    chk("floor.tch",    int'(w_tch[0]),    1);
    cyc(0, 0, 0, 0);

    // Leak on instance B (THRESHOLD 8, PUSH_DOWN 4): first fire on 10th inc
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 0, 1, 0);
      if (i < 10) chk("leak.nofire", int'(w_tvalid[1]), 0);
    end
    chk("leak.fire", int'(w_tvalid[1]), 1);
    chk("leak.tch",  int'(w_tch[1]),    0);
    cyc(0, 0, 0, 0);

    // FIFO backpressure on instance A (TRIG_DEPTH 2)
    do_reset();
    tready = 1'b0;
    repeat (3) cyc(1, 0, 1, 0);
    repeat (3) cyc(1, 1, 1, 0);
    repeat (3) cyc(1, 3, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 1, 1, 0);
    chk("bp.full.ready", int'(w_ready[0]), 0);
    chk("bp.head0",      int'(w_tch[0]),   0);
    ev_valid = 1'b1; ev_ch = 2'd3; ev_inc = 1'b1;
    #1 chk("bp.held.ready", int'(w_ready[0]), 0);
    tready = 1'b1;
    @(posedge clk); #1;
    chk("bp.head1",  int'(w_tch[0]),   1);
    chk("bp.ready1", int'(w_ready[0]), 1);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    chk("bp.third.tvalid", int'(w_tvalid[0]), 1);
    chk("bp.third.tch",    int'(w_tch[0]),    3);
    cyc(0, 0, 0, 0);
    chk("bp.drained", int'(w_tvalid[0]), 0);

    // Clear sweep with a queued trigger on instance A
    do_reset();
    tready = 1'b0;
    repeat (4) cyc(1, 0, 1, 0);
    repeat (3) cyc(1, 3, 1, 0);
    ev_valid = 1'b1; ev_ch = 2'd3; ev_inc = 1'b1; clr = 1'b1;
    #1 chk("clr.ready", int'(w_ready[0]), 0);
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      chk("sweep.busy",   int'(w_busy[0]),   1);
      chk("sweep.ready",  int'(w_ready[0]),  0);
      chk("sweep.tvalid", int'(w_tvalid[0]), 1);
      chk("sweep.tch",    int'(w_tch[0]),    0);
      @(posedge clk); #1;
    end
    ev_valid = 1'b0;
    chk("sweep.done.busy",  int'(w_busy[0]),  0);
    chk("sweep.done.ready", int'(w_ready[0]), 1);
    cyc(1, 3, 1, 0);
    chk("sweep.post.tch", int'(w_tch[0]), 0);
    tready = 1'b1;
    cyc(0, 0, 0, 0);
    chk("sweep.post.nofire", int'(w_tvalid[0]), 0);

`ifdef ACCUM_SCHED_STATS_EN
    // Push statistics: 20 incs on ch0 of A give 5 fires
    do_reset();
    tready = 1'b1;
    repeat (20) cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("stats.five", int'(w_total[0]), 5);
    cyc(0, 0, 0, 1);
    repeat (NCH + 1) cyc(0, 0, 0, 0);
    chk("stats.afterclr", int'(w_total[0]), 5);
    do_reset();
    chk("stats.afterrst", int'(w_total[0]), 0);
`endif

    // Randomized traffic, checked every cycle by the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ev_valid = ($urandom_range(0, 9) < 7);
      ev_ch    = 2'($urandom_range(0, 3));
      ev_inc   = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 99) < 2);
      tready   = ($urandom_range(0, 1) == 1);
      rst      = ($urandom_range(0, 999) < 4);
      @(posedge clk); #1;
    end
    rst = 1'b0; ev_valid = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_sched.md
ACCUM_SCHED -- requirements
Module: accum_sched

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of time-multiplexed leaky accumulator channels, minimum 2.
REQ-002 SHALL have parameter THRESHOLD, default 255: inc events needed to fire a channel, minimum 2; count width COUNT_W = $clog2(THRESHOLD).
REQ-003 SHALL have parameter PUSH_DOWN, default 16: per-channel event period between leak decrements, minimum 2.
REQ-004 SHALL have parameter TRIG_DEPTH, default 4: trigger FIFO entries, minimum 2.
REQ-005 SHALL have port clk_in, input, 1 bit: sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ev_valid_in, input, 1 bit: event offered.
REQ-008 SHALL have port ev_ready_out, output, 1 bit: event accepted this cycle if also valid.
REQ-009 SHALL have port ev_ch_in, input, $clog2(N_CH) bits: target channel.
REQ-010 SHALL have port ev_inc_in, input, 1 bit: 1 = increment event, 0 = decay event.
REQ-011 SHALL have port clr_in, input, 1 bit: pulse that starts a clear sweep.
REQ-012 SHALL have port trig_valid_out, output, 1 bit: FIFO head valid.
REQ-013 SHALL have port trig_ready_in, input, 1 bit: consumer pops head.
REQ-014 SHALL have port trig_ch_out, output, $clog2(N_CH) bits: channel that fired.
REQ-015 SHALL have port busy_out, output, 1 bit: high while in SWEEP.

Function
REQ-016 SHALL hold per-channel state in registers: count[ch] (COUNT_W bits) and timer[ch] (0..PUSH_DOWN-1).
REQ-017 SHALL implement a two-state FSM, RUN and SWEEP; busy_out = (state == SWEEP).
REQ-018 SHALL drive ev_ready_out = (state == RUN) && !clr_in && (FIFO occupancy < TRIG_DEPTH); the signal is combinational.
REQ-019 SHALL, on acceptance (ev_valid_in && ev_ready_out), update the addressed channel in the same edge: new_timer = (timer == PUSH_DOWN-1) ? 0 : timer+1.
REQ-020 SHALL set fire = ev_inc_in && (count == THRESHOLD-1); otherwise the base count SHALL be 0 on fire, count+1 on an inc event, and a saturating count-1 (floor 0) on a decay event.
REQ-021 SHALL apply an additional saturating decrement to the base count when new_timer == 0, including on a fire, where the result stays 0.
REQ-022 SHALL push ev_ch_in into the FIFO on fire; trig_valid_out is high from the cycle after acceptance, giving 1-cycle latency.
REQ-023 SHALL accept back-to-back events to the same channel every cycle, with each event observing the previous event's update.
REQ-024 SHALL leave non-addressed channels unchanged.
REQ-025 SHALL pop the FIFO on trig_valid_out && trig_ready_in; a simultaneous push and pop SHALL leave occupancy unchanged; order SHALL be FIFO.
REQ-026 SHALL transition RUN to SWEEP on clr_in, with no event accepted that cycle.
REQ-027 SHALL, in SWEEP, zero count and timer of channel 0, 1, ..., N_CH-1, one channel per cycle, then return to RUN; ev_ready_out SHALL be low for exactly N_CH cycles after the clr_in cycle.
REQ-028 SHALL restart the sweep at channel 0 when clr_in is asserted during SWEEP.
REQ-029 SHALL NOT flush the FIFO on sweep; queued triggers remain poppable during SWEEP.

Reset
REQ-030 SHALL, with rst_in high at an edge, clear all count and timer registers, empty the FIFO, and set state to RUN and sweep index to 0, overriding clr_in and all events.
REQ-031 SHALL hold trig_valid_out = 0 and busy_out = 0 in the cycle after reset; ev_ready_out SHALL be 1 when clr_in is low.

Configuration
REQ-032 SHALL, with macro ACCUM_SCHED_STATS_EN defined, add output trig_total_out [15:0]: count of FIFO pushes, saturating at 16'hFFFF, cleared by rst_in and not cleared by clr_in.
REQ-033 SHALL, without ACCUM_SCHED_STATS_EN, omit the port and counter; all other behaviour is identical.

Verification
REQ-034 SHALL cover: N_CH=4, THRESHOLD=4, PUSH_DOWN=16, trig_ready_in=1; 4 back-to-back inc events on ch2 -> trig_valid_out=1 with trig_ch_out=2 exactly one cycle after the 4th acceptance, and no trigger on ch0/1/3.
REQ-035 SHALL cover: THRESHOLD=4; ch1 inc, inc, decay, decay, decay, then 3 incs -> no trigger; the 4th subsequent inc fires, proving the floor at 0.
REQ-036 SHALL cover: THRESHOLD=8, PUSH_DOWN=4; 10 inc events on ch0 -> the first trigger occurs on the 10th event, not the 8th.
REQ-037 SHALL cover: TRIG_DEPTH=2, trig_ready_in=0; 3 firing events on ch0, ch1, ch3 -> ev_ready_out drops after 2 pushes; raising trig_ready_in pops ch0 then ch1, after which the 3rd event is accepted.
REQ-038 SHALL cover: THRESHOLD=4; ch3 given 3 incs, then clr_in pulse with ev_valid_in high -> busy_out=1 and ev_ready_out=0 for 4 cycles; next inc on ch3 does not fire; a queued trigger stays visible throughout.
REQ-039 SHALL cover: with ACCUM_SCHED_STATS_EN defined, 5 triggers -> trig_total_out=5; after clr_in still 5; after rst_in 0.
